// File: rtl/spi_rx_oversampled.sv
// rtl/spi_rx_oversampled.sv - oversampled SPI slave receiver with first-word-fall-through FIFO
module spi_rx_oversampled #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             spi_sck,
    input  logic             spi_csn,
    input  logic             spi_sdi,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overflow,
    input  logic             rx_clear_ovf,
    output logic             rx_partial,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAST = WIDTH - 1;
    localparam logic [CW-1:0] LAST_BIT = LAST[CW-1:0];
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    typedef enum logic [1:0] {
        WAIT_DESELECT,
        IDLE,
        ACTIVE
    } state_t;

    state_t state;
    state_t state_next;

    logic sck_s1, sck_s2, sck_s3;
    logic csn_s1, csn_s2;
    logic sdi_s1, sdi_s2;
    logic sck_rise, sck_fall, sample_edge;

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] word_next;
    logic             shift_en;
    logic             push;
    logic             drop_bits;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, pop, wr_en;

    // Bring the asynchronous pins into the system clock; SCK gets a third stage for edge detection
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sck_s1 <= CPOL;
            sck_s2 <= CPOL;
            sck_s3 <= CPOL;
            csn_s1 <= 1'b0;
            csn_s2 <= 1'b0;
            sdi_s1 <= 1'b0;
            sdi_s2 <= 1'b0;
        end else begin
            sck_s1 <= spi_sck;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            csn_s1 <= spi_csn;
            csn_s2 <= csn_s1;
            sdi_s1 <= spi_sdi;
            sdi_s2 <= sdi_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3;
    assign sck_fall = ~sck_s2 & sck_s3;
    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge
    assign sample_edge = (CPOL ^ CPHA) ? sck_fall : sck_rise;

    assign word_next = LSB_FIRST ? {sdi_s2, shift_reg[WIDTH-1:1]}
                                 : {shift_reg[WIDTH-2:0], sdi_s2};

    // Receiver state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= WAIT_DESELECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control: deselect takes priority over a same-cycle sample edge
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        push       = 1'b0;
        drop_bits  = 1'b0;
        case (state)
            WAIT_DESELECT: begin
                if (csn_s2) state_next = IDLE;
            end
            IDLE: begin
                if (!csn_s2) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (csn_s2) begin
                    state_next = IDLE;
                    drop_bits  = (bit_cnt != '0);
                end else if (sample_edge) begin
                    shift_en = 1'b1;
                    push     = (bit_cnt == LAST_BIT);
                end
            end
            default: state_next = WAIT_DESELECT;
        endcase
    end

    // Bit counter, shift register and the partial-word pulse
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_partial <= 1'b0;
        end else begin
            rx_partial <= drop_bits;
            if (state != ACTIVE || drop_bits) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (shift_en) begin
                shift_reg <= word_next;
                bit_cnt   <= push ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    assign full     = (count == FULL_COUNT);
    assign rx_valid = (count != '0);
    assign pop      = rx_valid & rx_ready;
    assign wr_en    = push & (~full | pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;
    assign busy     = (state == ACTIVE);

    // FIFO storage; stale entries are never visible because rx_data is gated by occupancy
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) mem[wr_ptr] <= word_next;
    end

    // FIFO pointers, occupancy and the sticky overflow flag (a new overflow beats a clear)
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end
            if (push && !wr_en) begin
                rx_overflow <= 1'b1;
            end else if (rx_clear_ovf) begin
                rx_overflow <= 1'b0;
            end
        end
    end
endmodule
